// File: rtl/bj_pkg.sv
// bj_pkg: shared types and constants for the blackjack round controller.
//   - bj_state_e : FSM state codes, reported on state_out
//   - bj_res_e   : per-hand result codes (NONE/WIN/LOSE/PUSH/BJ)
//   - bj_kind_e  : what the outstanding card request is for
//   - bj_score_t : the parts of a hand that settlement looks at
//   - bj_settle  : settles one player hand against the dealer
package bj_pkg;

    localparam logic [3:0] CARD_ACE = 4'd1;
    localparam logic [3:0] CARD_TEN = 4'd10;
    localparam logic [4:0] BJ_LIMIT = 5'd21;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_DEAL_P = 4'd1,
        S_DEAL_D = 4'd2,
        S_CHECK  = 4'd3,
        S_PLAY   = 4'd4,
        S_DEALER = 4'd5,
        S_SETTLE = 4'd6,
        S_DONE   = 4'd7,
        S_REQ    = 4'd8,   // card_on strobe
        S_WAIT   = 4'd9,   // sample card1_in/card2_in
        S_GAP    = 4'd10,  // idle after an empty card
        S_ADD2   = 4'd11,  // second card of a two-card deal
        S_FIN    = 4'd12   // active hand finished
    } bj_state_e;

    typedef enum logic [2:0] {
        RES_NONE = 3'd0,
        RES_WIN  = 3'd1,
        RES_LOSE = 3'd2,
        RES_PUSH = 3'd3,
        RES_BJ   = 3'd4
    } bj_res_e;

    typedef enum logic [2:0] {
        K_DEAL_P = 3'd0,
        K_DEAL_D = 3'd1,
        K_HIT    = 3'd2,
        K_DOUBLE = 3'd3,
        K_SPLIT0 = 3'd4,
        K_SPLIT1 = 3'd5,
        K_DEALER = 3'd6
    } bj_kind_e;

    typedef struct packed {
        logic [4:0] best;
        logic       bust;
        logic       natural;  // already qualified with "never split"
    } bj_score_t;

    function automatic bj_res_e bj_settle(input bj_score_t p, input bj_score_t d);
        if (p.bust)           return RES_LOSE;
        if (p.natural)        return d.natural ? RES_PUSH : RES_BJ;
        if (d.natural)        return RES_LOSE;
        if (d.bust)           return RES_WIN;
        if (p.best > d.best)  return RES_WIN;
        if (p.best < d.best)  return RES_LOSE;
        return RES_PUSH;
    endfunction

endpackage

// File: rtl/bj_hand_acc.sv
// bj_hand_acc: running score of one blackjack hand.
//   clk, reset_n : clock, async active-low reset
//   clear        : empty the hand (if add_en is also set, card becomes the only card)
//   add_en, card : add one card (1..10, 1 = ace)
//   hard         : hard sum, saturating at 31
//   best         : hard + 10 when an ace can count as 11
//   ace, count   : any ace seen, number of cards (saturating at 7)
//   bust         : best > 21
//   natural      : two-card 21 (split qualification is applied by the caller)
module bj_hand_acc
    import bj_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       clear,
    input  logic       add_en,
    input  logic [3:0] card,
    output logic [4:0] hard,
    output logic [4:0] best,
    output logic       ace,
    output logic [2:0] count,
    output logic       bust,
    output logic       natural
);

    logic [4:0] hard_q, hard_d;
    logic       ace_q, ace_d;
    logic [2:0] cnt_q, cnt_d;
    logic [5:0] sum;

    always_comb begin
        hard_d = hard_q;
        ace_d  = ace_q;
        cnt_d  = cnt_q;
        sum    = '0;
        if (clear) begin
            hard_d = '0;
            ace_d  = 1'b0;
            cnt_d  = '0;
        end
        if (add_en) begin
            sum    = {1'b0, hard_d} + {2'b0, card};
            hard_d = sum[5] ? 5'd31 : sum[4:0];
            ace_d  = ace_d | (card == CARD_ACE);
            if (cnt_d != 3'd7) cnt_d = cnt_d + 3'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hard_q <= '0;
            ace_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            hard_q <= hard_d;
            ace_q  <= ace_d;
            cnt_q  <= cnt_d;
        end
    end

    // Only one ace can ever count as 11, so the soft total is hard + 10.
    assign best    = (ace_q && hard_q <= 5'd11) ? hard_q + {1'b0, CARD_TEN} : hard_q;
    assign hard    = hard_q;
    assign ace     = ace_q;
    assign count   = cnt_q;
    assign bust    = best > BJ_LIMIT;
    assign natural = (cnt_q == 3'd2) && (best == BJ_LIMIT);

endmodule

// File: rtl/blackjack_round_ctrl.sv
// blackjack_round_ctrl: sequences one blackjack round.
//   clk, reset_n            : clock, async active-low reset
//   start                   : begin a round (IDLE/DONE only)
//   hit/stand/double_dn/split : player button pulses, accepted only in PLAY
//   card1_in, card2_in      : generator cards (0 = no card)
//   card_on                 : one-cycle card request
//   state_out, active_hand  : FSM state, hand being played
//   player_total0/1, dealer_total : best totals (dealer shows up card until revealed)
//   doubled, result0/1      : per-hand doubled flag and result code
//   card_err                : pulse when a needed card sampled as 0
//   round_done              : high in DONE
module blackjack_round_ctrl
    import bj_pkg::*;
#(
    parameter int DEALER_STAND = 17,
    parameter int RETRY_GAP    = 1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic       hit,
    input  logic       stand,
    input  logic       double_dn,
    input  logic       split,
    input  logic [3:0] card1_in,
    input  logic [3:0] card2_in,
    output logic       card_on,
    output logic [3:0] state_out,
    output logic       active_hand,
    output logic [4:0] player_total0,
    output logic [4:0] player_total1,
    output logic [4:0] dealer_total,
    output logic [1:0] doubled,
    output logic [2:0] result0,
    output logic [2:0] result1,
    output logic       card_err,
    output logic       round_done
);

    localparam logic [4:0] STAND_AT = 5'(DEALER_STAND);
    localparam logic [7:0] GAP_INIT = 8'(RETRY_GAP - 1);

    bj_state_e  state_q, state_d;
    bj_kind_e   kind_q, kind_d;
    logic [7:0] gap_q, gap_d;
    logic       active_q, active_d;
    logic       split_q, split_d;
    logic       reveal_q, reveal_d;
    logic [1:0] dbl_q, dbl_d;
    bj_res_e    res0_q, res0_d, res1_q, res1_d;
    logic [4:0] up_q, up_d;       // dealer up-card value shown before reveal
    logic [3:0] pend_q, pend_d;   // card2 of a deal, added the cycle after card1
    logic [3:0] c1_q, c1_d;       // player's first two cards, kept for a split
    logic [3:0] c2_q, c2_d;

    // accumulator index: 0 = hand 0, 1 = hand 1, 2 = dealer
    logic [2:0]      acc_clr, acc_add;
    logic [2:0][3:0] acc_card;
    logic [2:0][4:0] h_hard, h_best;
    logic [2:0][2:0] h_cnt;
    logic [2:0]      h_ace, h_bust, h_nat;

    genvar gi;
    for (gi = 0; gi < 3; gi++) begin : g_acc
        bj_hand_acc u_acc (
            .clk     (clk),
            .reset_n (reset_n),
            .clear   (acc_clr[gi]),
            .add_en  (acc_add[gi]),
            .card    (acc_card[gi]),
            .hard    (h_hard[gi]),
            .best    (h_best[gi]),
            .ace     (h_ace[gi]),
            .count   (h_cnt[gi]),
            .bust    (h_bust[gi]),
            .natural (h_nat[gi])
        );
    end

    // Hard sums and ace flags only matter inside the accumulators.
    logic unused_acc;
    assign unused_acc = ^{h_hard, h_ace, h_cnt[2]};

    bj_score_t p0_sc, p1_sc, d_sc;
    assign p0_sc = {h_best[0], h_bust[0], h_nat[0] & ~split_q};
    assign p1_sc = {h_best[1], h_bust[1], h_nat[1] & ~split_q};
    assign d_sc  = {h_best[2], h_bust[2], h_nat[2]};

    logic       cur_bust, all_bust, split_ok, need2, bad_card;
    logic [2:0] cur_cnt;
    assign cur_bust = active_q ? h_bust[1] : h_bust[0];
    assign cur_cnt  = active_q ? h_cnt[1]  : h_cnt[0];
    assign all_bust = h_bust[0] & (~split_q | h_bust[1]);
    assign split_ok = ~active_q & ~split_q & (h_cnt[0] == 3'd2) & (c1_q == c2_q);
    assign need2    = (kind_q == K_DEAL_P) || (kind_q == K_DEAL_D);
    assign bad_card = (card1_in == 4'd0) || (need2 && card2_in == 4'd0);

    always_comb begin
        state_d  = state_q;
        kind_d   = kind_q;
        gap_d    = gap_q;
        active_d = active_q;
        split_d  = split_q;
        reveal_d = reveal_q;
        dbl_d    = dbl_q;
        res0_d   = res0_q;
        res1_d   = res1_q;
        up_d     = up_q;
        pend_d   = pend_q;
        c1_d     = c1_q;
        c2_d     = c2_q;
        acc_clr  = '0;
        acc_add  = '0;
        acc_card = '0;
        card_on  = 1'b0;
        card_err = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    acc_clr  = 3'b111;
                    active_d = 1'b0;
                    split_d  = 1'b0;
                    reveal_d = 1'b0;
                    dbl_d    = '0;
                    res0_d   = RES_NONE;
                    res1_d   = RES_NONE;
                    up_d     = '0;
                    state_d  = S_DEAL_P;
                end
            end
            S_DEAL_P: begin
                kind_d  = K_DEAL_P;
                state_d = S_REQ;
            end
            S_DEAL_D: begin
                kind_d  = K_DEAL_D;
                state_d = S_REQ;
            end
            S_REQ: begin
                card_on = 1'b1;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (bad_card) begin
                    // Nothing is added; the same request is simply repeated.
                    card_err = 1'b1;
                    if (RETRY_GAP == 0) begin
                        state_d = S_REQ;
                    end else begin
                        gap_d   = GAP_INIT;
                        state_d = S_GAP;
                    end
                end else begin
                    case (kind_q)
                        K_DEAL_P: begin
                            acc_add[0]  = 1'b1;
                            acc_card[0] = card1_in;
                            c1_d        = card1_in;
                            c2_d        = card2_in;
                            pend_d      = card2_in;
                            state_d     = S_ADD2;
                        end
                        K_DEAL_D: begin
                            acc_add[2]  = 1'b1;
                            acc_card[2] = card1_in;
                            up_d        = (card1_in == CARD_ACE) ? {1'b0, CARD_TEN} + 5'd1
                                                                 : {1'b0, card1_in};
                            pend_d      = card2_in;
                            state_d     = S_ADD2;
                        end
                        K_DEALER: begin
                            acc_add[2]  = 1'b1;
                            acc_card[2] = card1_in;
                            state_d     = S_DEALER;
                        end
                        default: begin
                            // hit, double, split follow-ups: card goes to the active hand
                            if (active_q) begin
                                acc_add[1]  = 1'b1;
                                acc_card[1] = card1_in;
                            end else begin
                                acc_add[0]  = 1'b1;
                                acc_card[0] = card1_in;
                            end
                            state_d = (kind_q == K_DOUBLE) ? S_FIN : S_PLAY;
                        end
                    endcase
                end
            end
            S_ADD2: begin
                if (kind_q == K_DEAL_P) begin
                    acc_add[0]  = 1'b1;
                    acc_card[0] = pend_q;
                    state_d     = S_DEAL_D;
                end else begin
                    acc_add[2]  = 1'b1;
                    acc_card[2] = pend_q;
                    state_d     = S_CHECK;
                end
            end
            S_CHECK: begin
                if (p0_sc.natural || d_sc.natural) begin
                    reveal_d = 1'b1;
                    state_d  = S_SETTLE;
                end else begin
                    active_d = 1'b0;
                    state_d  = S_PLAY;
                end
            end
            S_PLAY: begin
                // Bust closes the hand before any button is looked at; 21 does not.
                if (cur_bust || stand) begin
                    state_d = S_FIN;
                end else if (double_dn && cur_cnt == 3'd2) begin
                    if (active_q) dbl_d[1] = 1'b1;
                    else          dbl_d[0] = 1'b1;
                    kind_d  = K_DOUBLE;
                    state_d = S_REQ;
                end else if (split && split_ok) begin
                    // Rebuild both hands from the kept deal cards in one cycle.
                    split_d     = 1'b1;
                    acc_clr[0]  = 1'b1;
                    acc_add[0]  = 1'b1;
                    acc_card[0] = c1_q;
                    acc_clr[1]  = 1'b1;
                    acc_add[1]  = 1'b1;
                    acc_card[1] = c2_q;
                    kind_d      = K_SPLIT0;
                    state_d     = S_REQ;
                end else if (hit) begin
                    kind_d  = K_HIT;
                    state_d = S_REQ;
                end
            end
            S_FIN: begin
                if (!active_q && split_q) begin
                    active_d = 1'b1;
                    kind_d   = K_SPLIT1;
                    state_d  = S_REQ;
                end else begin
                    reveal_d = 1'b1;
                    state_d  = all_bust ? S_SETTLE : S_DEALER;
                end
            end
            S_DEALER: begin
                if (h_best[2] < STAND_AT) begin
                    kind_d  = K_DEALER;
                    state_d = S_REQ;
                end else begin
                    state_d = S_SETTLE;
                end
            end
            S_SETTLE: begin
                res0_d  = bj_settle(p0_sc, d_sc);
                res1_d  = split_q ? bj_settle(p1_sc, d_sc) : RES_NONE;
                state_d = S_DONE;
            end
            S_GAP: begin
                if (gap_q == 8'd0) state_d = S_REQ;
                else               gap_d   = gap_q - 8'd1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            kind_q   <= K_DEAL_P;
            gap_q    <= '0;
            active_q <= 1'b0;
            split_q  <= 1'b0;
            reveal_q <= 1'b0;
            dbl_q    <= '0;
            res0_q   <= RES_NONE;
            res1_q   <= RES_NONE;
            up_q     <= '0;
            pend_q   <= '0;
            c1_q     <= '0;
            c2_q     <= '0;
        end else begin
            state_q  <= state_d;
            kind_q   <= kind_d;
            gap_q    <= gap_d;
            active_q <= active_d;
            split_q  <= split_d;
            reveal_q <= reveal_d;
            dbl_q    <= dbl_d;
            res0_q   <= res0_d;
            res1_q   <= res1_d;
            up_q     <= up_d;
            pend_q   <= pend_d;
            c1_q     <= c1_d;
            c2_q     <= c2_d;
        end
    end

    assign state_out     = state_q;
    assign active_hand   = active_q;
    assign player_total0 = h_best[0];
    assign player_total1 = h_best[1];
    assign dealer_total  = reveal_q ? h_best[2] : up_q;
    assign doubled       = dbl_q;
    assign result0       = res0_q;
    assign result1       = res1_q;
    assign round_done    = (state_q == S_DONE);

endmodule

// File: tb/tb_blackjack_round_ctrl.sv
// Directed bench for blackjack_round_ctrl. A small card feeder hands out the
// next queued (card1, card2) pair every time card_on is seen.
module tb_blackjack_round_ctrl;
    import bj_pkg::*;

    logic       clk = 1'b0;
    logic       reset_n, start, hit, stand, double_dn, split;
    logic [3:0] card1_in, card2_in;
    logic       card_on, active_hand, card_err, round_done;
    logic [3:0] state_out;
    logic [4:0] player_total0, player_total1, dealer_total;
    logic [1:0] doubled;
    logic [2:0] result0, result1;

    int n_chk  = 0;
    int n_pass = 0;
    int n_req  = 0;
    int n_err  = 0;
    int base, ebase;
    logic [3:0] q1[$];
    logic [3:0] q2[$];

    blackjack_round_ctrl #(.DEALER_STAND(17), .RETRY_GAP(1)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .start         (start),
        .hit           (hit),
        .stand         (stand),
        .double_dn     (double_dn),
        .split         (split),
        .card1_in      (card1_in),
        .card2_in      (card2_in),
        .card_on       (card_on),
        .state_out     (state_out),
        .active_hand   (active_hand),
        .player_total0 (player_total0),
        .player_total1 (player_total1),
        .dealer_total  (dealer_total),
        .doubled       (doubled),
        .result0       (result0),
        .result1       (result1),
        .card_err      (card_err),
        .round_done    (round_done)
    );

    always #5 clk = ~clk;

    // card generator stand-in: cards are valid from the REQ cycle's low phase on
    always @(negedge clk) begin
        if (card_err) n_err++;
        if (card_on) begin
            n_req++;
            if (q1.size() > 0) begin
                card1_in = q1.pop_front();
                card2_in = q2.pop_front();
            end else begin
                card1_in = 4'd0;
                card2_in = 4'd0;
            end
        end
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic push(input logic [3:0] a, input logic [3:0] b);
        q1.push_back(a);
        q2.push_back(b);
    endtask

    task automatic wait_st(input bj_state_e st, input string tag);
        for (int i = 0; i < 200 && state_out != st; i++) @(negedge clk);
        chk(tag, int'(state_out), int'(st));
    endtask

    task automatic press(input logic h, input logic s, input logic d, input logic sp);
        hit = h; stand = s; double_dn = d; split = sp;
        @(negedge clk);
        hit = 1'b0; stand = 1'b0; double_dn = 1'b0; split = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; start = 1'b0; hit = 1'b0; stand = 1'b0;
        double_dn = 1'b0; split = 1'b0; card1_in = 4'd0; card2_in = 4'd0;
        repeat (2) @(negedge clk);
        chk("rst_state", int'(state_out), int'(S_IDLE));
        chk("rst_p0", int'(player_total0), 0);
        chk("rst_dealer", int'(dealer_total), 0);
        chk("rst_card_on", int'(card_on), 0);
        chk("rst_result0", int'(result0), int'(RES_NONE));
        chk("rst_done", int'(round_done), 0);
        reset_n = 1'b1;
        @(negedge clk);

        // simple: 18 vs dealer 4,6 -> draws 4, 10 -> bust
        push(10, 8); push(4, 6); push(4, 0); push(10, 0);
        base = n_req;
        pulse_start();
        wait_st(S_PLAY, "simple_play");
        chk("simple_p0", int'(player_total0), 18);
        chk("simple_up", int'(dealer_total), 4);
        chk("simple_act", int'(active_hand), 0);
        press(0, 1, 0, 0);
        wait_st(S_DONE, "simple_done");
        chk("simple_res", int'(result0), int'(RES_WIN));
        chk("simple_dealer", int'(dealer_total), 24);
        chk("simple_rdone", int'(round_done), 1);
        chk("simple_reqs", n_req - base, 4);
        press(1, 0, 0, 0);  // ignored outside PLAY
        repeat (3) @(negedge clk);
        chk("done_hit_ign", n_req - base, 4);
        chk("done_hold", int'(result0), int'(RES_WIN));

        // double: 18 + 2 = 20 vs dealer 20 -> push
        push(10, 8); push(10, 10); push(2, 0);
        pulse_start();
        wait_st(S_PLAY, "dbl_play");
        press(0, 0, 1, 0);
        wait_st(S_DONE, "dbl_done");
        chk("dbl_p0", int'(player_total0), 20);
        chk("dbl_flag", int'(doubled), 1);
        chk("dbl_res", int'(result0), int'(RES_PUSH));
        chk("dbl_dealer", int'(dealer_total), 20);

        // blackjack: natural settles straight from CHECK
        push(10, 1); push(8, 9);
        base = n_req;
        pulse_start();
        wait_st(S_DONE, "bj_done");
        chk("bj_res", int'(result0), int'(RES_BJ));
        chk("bj_dealer", int'(dealer_total), 17);
        chk("bj_reqs", n_req - base, 2);
        chk("bj_p0", int'(player_total0), 21);
        chk("bj_dbl_clr", int'(doubled), 0);

        // split: 10+8 and 10+4 vs dealer 20
        push(10, 10); push(10, 10); push(8, 0); push(4, 0);
        pulse_start();
        wait_st(S_PLAY, "spl_play");
        chk("spl_p1_pre", int'(player_total1), 0);
        press(0, 0, 0, 1);
        wait_st(S_PLAY, "spl_play0");
        chk("spl_h0", int'(player_total0), 18);
        chk("spl_h1_pre", int'(player_total1), 10);
        chk("spl_act0", int'(active_hand), 0);
        press(0, 1, 0, 0);
        wait_st(S_PLAY, "spl_play1");
        chk("spl_act1", int'(active_hand), 1);
        chk("spl_h1", int'(player_total1), 14);
        press(0, 1, 0, 0);
        wait_st(S_DONE, "spl_done");
        chk("spl_res0", int'(result0), int'(RES_LOSE));
        chk("spl_res1", int'(result1), int'(RES_LOSE));
        chk("spl_dealer", int'(dealer_total), 20);

        // hit+stand together: stand wins, no card drawn; 16 vs 17
        push(9, 7); push(10, 7);
        pulse_start();
        wait_st(S_PLAY, "pri_play");
        base = n_req;
        press(1, 1, 0, 0);
        wait_st(S_DONE, "pri_done");
        chk("pri_reqs", n_req - base, 0);
        chk("pri_res", int'(result0), int'(RES_LOSE));
        chk("pri_p0", int'(player_total0), 16);
        chk("pri_res1", int'(result1), int'(RES_NONE));

        // split on 10,8 ignored; empty card retried; double after hit ignored
        push(10, 8); push(10, 5); push(0, 0); push(2, 0); push(3, 0);
        pulse_start();
        wait_st(S_PLAY, "ill_play");
        base = n_req; ebase = n_err;
        press(0, 0, 0, 1);
        repeat (3) @(negedge clk);
        chk("ill_spl_st", int'(state_out), int'(S_PLAY));
        chk("ill_spl_req", n_req - base, 0);
        chk("ill_spl_p1", int'(player_total1), 0);
        press(1, 0, 0, 0);
        wait_st(S_PLAY, "ill_hit");
        chk("ill_err", n_err - ebase, 1);
        chk("ill_p0", int'(player_total0), 20);
        chk("ill_hit_req", n_req - base, 2);
        press(0, 0, 1, 0);
        repeat (3) @(negedge clk);
        chk("ill_dbl_st", int'(state_out), int'(S_PLAY));
        chk("ill_dbl_flag", int'(doubled), 0);
        chk("ill_dbl_req", n_req - base, 2);
        press(0, 1, 0, 0);
        wait_st(S_DONE, "ill_done");
        chk("ill_res", int'(result0), int'(RES_WIN));
        chk("ill_dealer", int'(dealer_total), 18);

        // async reset while the dealer is drawing
        push(10, 8); push(4, 6); push(4, 0); push(10, 0);
        pulse_start();
        wait_st(S_PLAY, "rr_play");
        press(0, 1, 0, 0);
        wait_st(S_DEALER, "rr_dealer");
        reset_n = 1'b0;
        #1;
        chk("rr_state", int'(state_out), int'(S_IDLE));
        chk("rr_p0", int'(player_total0), 0);
        chk("rr_dealer_t", int'(dealer_total), 0);
        chk("rr_card_on", int'(card_on), 0);
        chk("rr_res", int'(result0), int'(RES_NONE));
        q1.delete(); q2.delete();
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        push(10, 8); push(4, 6); push(4, 0); push(10, 0);
        pulse_start();
        wait_st(S_PLAY, "rr2_play");
        press(0, 1, 0, 0);
        wait_st(S_DONE, "rr2_done");
        chk("rr2_res", int'(result0), int'(RES_WIN));
        chk("rr2_p0", int'(player_total0), 18);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
